tacc_uni: RTL and testbench
===========================

TACC_UNI -- requirements
Module: tacc_uni

Interface
REQ-001 Parameter LANES, default 16, number of tMUL_uni lanes consumed (power of two, 2..64).
REQ-002 Parameter ACC_W, default 12, accumulator width; SHALL equal 8+log2(LANES).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active low.
REQ-005 start  in  1  request one MAC pass; accepted when start && start_ready.
REQ-006 start_ready  out  1  high only in IDLE.
REQ-007 loadA  out  1  broadcast load strobe to all lanes' A counters.
REQ-008 loadB  out  1  broadcast load strobe to all lanes' B registers.
REQ-009 mul_oC  in  LANES  per-lane unipolar product bitstream.
REQ-010 mul_stop  in  LANES  per-lane stop flag (1 = lane finished or idle).
REQ-011 acc_out  out  ACC_W  count of product ones for the last pass; stable while out_valid.
REQ-012 out_valid  out  1  result available; held until out_ready.
REQ-013 out_ready  in  1  consumer accepts result when out_valid && out_ready.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err  out  1  timeout flag for the current result (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SETTLE, RUN, DONE, one-hot or binary, no others.
REQ-017 IDLE: start accepted -> LOAD; acc cleared to 0 in the same edge.
REQ-018 LOAD: loadA=loadB=1 for exactly one cycle, otherwise both 0 in all states; -> SETTLE.
REQ-019 SETTLE: one cycle ignoring mul_oC/mul_stop (lane stop still registered from load); -> RUN.
REQ-020 RUN: each cycle acc <= acc + popcount(mul_oC & ~mul_stop), zero-extended to ACC_W.
REQ-021 RUN: when all mul_stop bits are 1 in a cycle, that cycle adds 0 and FSM -> DONE.
REQ-022 Lane with A=0 SHALL hold stop=1 throughout; all-zero A gives exactly one RUN cycle, acc_out=0.
REQ-023 Latency: from start-accept edge, out_valid rises after 3+maxA+1 cycles (maxA = largest loaded A).
REQ-024 DONE: out_valid=1, acc_out=acc; on out_valid && out_ready -> IDLE, out_valid drops next cycle.
REQ-025 start while not IDLE SHALL be ignored (start_ready=0); no queuing.
REQ-026 Accumulator SHALL not wrap: LANES*255 fits ACC_W by REQ-002.
REQ-027 out_ready asserted outside DONE has no effect.

Reset
REQ-028 rst_n low: state=IDLE, acc=0, loadA=loadB=0, out_valid=0, busy=0, err=0, start_ready=1 after release.
REQ-029 Reset mid-RUN aborts the pass; no partial result is presented.
REQ-030 First start SHALL be accepted in the first clock after rst_n deasserts.

Configuration
REQ-031 Macro TACC_UNI_TIMEOUT_EN defined: 9-bit RUN cycle counter; at 257 RUN cycles without all-stop, FSM -> DONE with err=1 and acc_out = acc at that point.
REQ-032 With timeout, err is cleared on the next start accept and on reset.
REQ-033 Macro undefined: no counter, err tied 0, RUN waits indefinitely for all-stop.

Verification
REQ-034 LANES=16, all A=10, B=255 (oC=1 while running) -> acc_out=160, out_valid 14 cycles after start accept.
REQ-035 All A=0 -> one RUN cycle, acc_out=0, out_valid 4 cycles after start accept.
REQ-036 A lane i = i (0..15), B=255 -> acc_out=120; DONE after maxA=15 RUN cycles plus exit cycle.
REQ-037 Hold out_ready=0 for 5 cycles in DONE, toggle start -> acc_out stable, start ignored, IDLE after ready.
REQ-038 rst_n pulsed during RUN with A=200 -> all outputs at reset values, next pass with A=3, B=255 gives 48.
REQ-039 TIMEOUT_EN, mul_stop forced 0 with oC=1 on lane 0 -> DONE after 257 RUN cycles, err=1, acc_out=257.

Source files
------------

// File: rtl/tacc_uni.sv
// Unipolar stochastic MAC accumulator: sequences a load/settle/run pass over LANES
// tMUL_uni lanes, counts product ones until every lane stops. Optional RUN timeout via TACC_UNI_TIMEOUT_EN.
module tacc_uni #(
   parameter int LANES = 16,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             start_ready,
   output logic             loadA,
   output logic             loadB,
   input  logic [LANES-1:0] mul_oC,
   input  logic [LANES-1:0] mul_stop,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             err
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   function automatic logic [ACC_W-1:0] popcnt(input logic [LANES-1:0] v);
      logic [ACC_W-1:0] c;
      c = {ACC_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         c = c + {{(ACC_W-1){1'b0}}, v[i]};
      end
      return c;
   endfunction

   logic [2:0]       state_r;
   logic [2:0]       nxt_s;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] add_s;
   logic             accept_s;
   logic             load_r;
   logic             start_ready_r;
   logic             busy_r;
   logic             out_valid_r;
   logic             timeout_s;

`ifdef TACC_UNI_TIMEOUT_EN
   logic [8:0]       run_cnt_r;
   logic             err_r;
`endif

   assign accept_s = start && start_ready_r;

   // next-state and per-cycle increment
   always_comb begin
      nxt_s     = state_r;
      add_s     = {ACC_W{1'b0}};
      timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) nxt_s = ST_LOAD;
            else          nxt_s = ST_IDLE;
         end
         ST_LOAD:   nxt_s = ST_SETTLE;
         ST_SETTLE: nxt_s = ST_RUN;
         ST_RUN: begin
            if (&mul_stop) begin
               nxt_s = ST_DONE;
            end else begin
               add_s = popcnt(mul_oC & ~mul_stop);
`ifdef TACC_UNI_TIMEOUT_EN
               // the 257th non-stopped RUN cycle still contributes before giving up
               if (run_cnt_r == 9'd256) begin
                  nxt_s     = ST_DONE;
                  timeout_s = 1'b1;
               end else begin
                  nxt_s = ST_RUN;
               end
`else
               nxt_s = ST_RUN;
`endif
            end
         end
         ST_DONE: begin
            if (out_ready) nxt_s = ST_IDLE;
            else           nxt_s = ST_DONE;
         end
         default: nxt_s = ST_IDLE;
      endcase
   end

   // state and registered control outputs, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         load_r        <= 1'b0;
         start_ready_r <= 1'b1;
         busy_r        <= 1'b0;
         out_valid_r   <= 1'b0;
      end else begin
         state_r       <= nxt_s;
         load_r        <= (nxt_s == ST_LOAD);
         start_ready_r <= (nxt_s == ST_IDLE);
         busy_r        <= (nxt_s != ST_IDLE);
         out_valid_r   <= (nxt_s == ST_DONE);
      end
   end

   // accumulator: cleared on accept, only moves during RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (accept_s) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (state_r == ST_RUN) begin
         acc_r <= acc_r + add_s;
      end else begin
         acc_r <= acc_r;
      end
   end

`ifdef TACC_UNI_TIMEOUT_EN
   // RUN cycle counter and sticky timeout flag for the current result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_r <= 9'd0;
         err_r     <= 1'b0;
      end else begin
         if (state_r == ST_SETTLE)   run_cnt_r <= 9'd0;
         else if (state_r == ST_RUN) run_cnt_r <= run_cnt_r + 9'd1;
         else                        run_cnt_r <= run_cnt_r;
         if (accept_s)       err_r <= 1'b0;
         else if (timeout_s) err_r <= 1'b1;
         else                err_r <= err_r;
      end
   end
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   assign start_ready = start_ready_r;
   assign loadA       = load_r;
   assign loadB       = load_r;
   assign busy        = busy_r;
   assign out_valid   = out_valid_r;
   assign acc_out     = acc_r;

endmodule

// File: tb/tb_tacc_uni.sv
// Directed bench for tacc_uni with a behavioural model of 16 tMUL_uni lanes at B=255.
module tb_tacc_uni;

   localparam int LANES = 16;
   localparam int ACC_W = 12;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             out_ready = 1'b0;
   logic             start_ready, loadA, loadB, out_valid, busy, err;
   logic [LANES-1:0] mul_oC, mul_stop;
   logic [ACC_W-1:0] acc_out;

   int total = 0;
   int bad   = 0;

   logic [7:0] a_cfg    [LANES];
   logic [7:0] lane_cnt [LANES];
   logic       lane_hold = 1'b0;
   logic       force_run = 1'b0;

   tacc_uni #(.LANES(LANES), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
      .loadA(loadA), .loadB(loadB), .mul_oC(mul_oC), .mul_stop(mul_stop),
      .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // lane model: load A on loadA, hold one settle cycle, then emit one '1' per cycle until A spent
   always @(posedge clk) begin
      lane_hold <= loadA;
      for (int i = 0; i < LANES; i++) begin
         if (!rst_n)                                          lane_cnt[i] <= 8'd0;
         else if (loadA)                                      lane_cnt[i] <= a_cfg[i];
         else if (!lane_hold && lane_cnt[i] != 8'd0)          lane_cnt[i] <= lane_cnt[i] - 8'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         mul_stop[i] = force_run ? 1'b0 : (lane_cnt[i] == 8'd0);
         mul_oC[i]   = force_run ? (i == 0) : (lane_cnt[i] != 8'd0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_all(input int a);
      for (int i = 0; i < LANES; i++) a_cfg[i] = a[7:0];
   endtask

   // Latency counts clock edges from the cycle in which start is presented (accept edge = 1).
   task automatic do_pass(input string tag, input int exp_lat, input int exp_acc, input logic exp_err);
      int n;
      int loads;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      loads = loadA ? 1 : 0;
      chk({tag, "_ready_drop"}, start_ready, 1'b0);
      while (!out_valid && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (loadA) loads++;
      end
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_acc"}, acc_out, exp_acc);
      chk({tag, "_loads"}, loads, 1);
      chk({tag, "_err"}, err, exp_err);
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 1'b0);
      chk({tag, "_idle"}, start_ready, 1'b1);
   endtask

   initial begin
      set_all(0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", start_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_load", {loadA, loadB}, 2'b00);
      chk("rst_err", err, 1'b0);
      chk("rst_acc", acc_out, 0);
      rst_n = 1'b1;

      // out_ready outside DONE does nothing
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk("early_ready", {busy, out_valid}, 2'b00);

      set_all(10);
      do_pass("a10", 14, 160, 1'b0);
      consume("a10");

      set_all(0);
      do_pass("a0", 4, 0, 1'b0);
      consume("a0");

      for (int i = 0; i < LANES; i++) a_cfg[i] = i[7:0];
      do_pass("ramp", 19, 120, 1'b0);
      consume("ramp");

      // hold result, poke start while in DONE
      set_all(5);
      do_pass("hold", 9, 80, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); start = ~start;
         @(posedge clk); #1;
         chk("hold_acc", acc_out, 80);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_noaccept", start_ready, 1'b0);
      end
      @(negedge clk); start = 1'b0;
      consume("hold");
      @(posedge clk); #1;
      chk("hold_no_queue", busy, 1'b0);

      // reset mid-RUN
      set_all(200);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("mid_busy", busy, 1'b1);
      chk("mid_valid", out_valid, 1'b0);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ready", start_ready, 1'b1);
      chk("mid_rst_acc", acc_out, 0);
      chk("mid_rst_misc", {out_valid, loadA, loadB, err}, 4'b0000);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      set_all(3);
      do_pass("after_rst", 7, 48, 1'b0);
      consume("after_rst");

`ifdef TACC_UNI_TIMEOUT_EN
      force_run = 1'b1;
      do_pass("tmo", 260, 257, 1'b1);
      consume("tmo");
      force_run = 1'b0;
      chk("tmo_err_held", err, 1'b1);
      set_all(1);
      do_pass("tmo_clear", 5, 16, 1'b0);
      consume("tmo_clear");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
